// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG debug transport module: TAP states,
// IR codes, DMI op/status codes and the DTMCS field layout.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SHIFT_DR = 4'd4,
        TAP_EXIT1_DR = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EXIT2_DR = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SHIFT_IR = 4'd11,
        TAP_EXIT1_IR = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EXIT2_IR = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_WORD   = 2'd1,
        DR_DMI    = 2'd2
    } dr_sel_e;

    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_DTMCS   = 5'h10;
    localparam logic [4:0] IR_DMI     = 5'h11;
    localparam logic [4:0] IR_BYPASS  = 5'h1F;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

    localparam logic [1:0] DMI_OP_NOP     = 2'd0;
    localparam logic [1:0] DMI_OP_READ    = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE   = 2'd2;
    localparam logic [1:0] DMI_STAT_BUSY  = 2'd3;

    localparam int         DTMCS_DMIRESET_BIT  = 16;
    localparam int         DTMCS_HARDRESET_BIT = 17;
    localparam logic [2:0] DTMCS_IDLE          = 3'd5;
    localparam logic [3:0] DTMCS_VERSION       = 4'd1;

    function automatic logic [31:0] dtmcs_word(input logic [1:0] dmistat, input logic [5:0] abits);
        return {14'b0, 1'b0, 1'b0, 1'b0, DTMCS_IDLE, dmistat, abits, DTMCS_VERSION};
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller stepped by the oversampled TCK rise pulse;
// exposes registered one-hot flags for the states the DTM acts on.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tck_rise,
    input  logic tms,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic tlr
);

    tap_state_e state_r;
    tap_state_e state_s;

    // State register and flag register, both loaded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= TAP_TLR;
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
            capture_ir <= 1'b0;
            shift_ir   <= 1'b0;
            update_ir  <= 1'b0;
            tlr        <= 1'b1;
        end else begin
            state_r    <= state_s;
            capture_dr <= (state_s == TAP_CAP_DR);
            shift_dr   <= (state_s == TAP_SHIFT_DR);
            update_dr  <= (state_s == TAP_UPD_DR);
            capture_ir <= (state_s == TAP_CAP_IR);
            shift_ir   <= (state_s == TAP_SHIFT_IR);
            update_ir  <= (state_s == TAP_UPD_IR);
            tlr        <= (state_s == TAP_TLR);
        end
    end

    // Next-state logic, advancing only on a TCK rise
    always_comb begin
        state_s = state_r;
        if (tck_rise) begin
            case (state_r)
                TAP_TLR:      state_s = tms ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      state_s = tms ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   state_s = tms ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state_s = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state_s = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state_s = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_s = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state_s = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state_s = tms ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   state_s = tms ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   state_s = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state_s = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state_s = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_s = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state_s = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state_s = tms ? TAP_SEL_DR   : TAP_RTI;
                default:      state_s = TAP_TLR;
            endcase
        end else begin
            state_s = state_r;
        end
    end

endmodule

// File: rtl/jtag_dtm_sync.sv
// Single-clock RISC-V JTAG DTM: oversampled pins, IR/DR shifting, DMI handshake.
// Build option: JTAG_IDCODE_EN enables the IDCODE instruction (otherwise 0x01 is BYPASS).
module jtag_dtm_sync
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = 32'h1E200A6D,
    parameter int          DMI_ABITS  = 6,
    parameter int          IR_BITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jtag_TCK,
    input  logic                  jtag_TMS,
    input  logic                  jtag_TDI,
    output logic                  jtag_TDO,
    output logic                  dtm_req_valid,
    input  logic                  dtm_req_ready,
    output logic [DMI_ABITS+33:0] dtm_req_data,
    input  logic                  dm_resp_valid,
    output logic                  dm_resp_ready,
    input  logic [33:0]           dm_resp_data
);

    localparam int DMI_W = DMI_ABITS + 34;
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_BITS-1:0] IR_RESET = IR_BITS'(IR_IDCODE);
`else
    localparam logic [IR_BITS-1:0] IR_RESET = IR_BITS'(IR_BYPASS);
    logic unused_idcode_s;
    assign unused_idcode_s = ^IDCODE_VAL;
`endif

    logic [2:0]         tck_sync_r;
    logic [1:0]         tms_sync_r;
    logic [1:0]         tdi_sync_r;
    logic               tck_rise_s;
    logic               tck_fall_s;
    logic               tms_s;
    logic               tdi_s;

    logic               capture_dr_s, shift_dr_s, update_dr_s;
    logic               capture_ir_s, shift_ir_s, update_ir_s, tlr_s;

    logic [IR_BITS-1:0] ir_r;
    logic [IR_BITS-1:0] ir_shift_r;
    logic [DMI_W-1:0]   dr_shift_r;
    logic [DMI_W-1:0]   dr_capture_s;
    logic [DMI_W-1:0]   dr_next_s;
    dr_sel_e            dr_sel_s;

    logic [1:0]         dmistat_r;
    logic               outstanding_r;
    logic [33:0]        resp_r;
    logic [1:0]         dmi_status_s;
    logic               resp_fire_s;
    logic               dmi_capture_s;
    logic               dmi_update_s;
    logic               dtmcs_update_s;
    logic               dmireset_s;
    logic               hardreset_s;
    logic               issue_s;

    // Pin synchronisers; the extra TCK stage feeds the edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync_r <= 3'b000;
            tms_sync_r <= 2'b00;
            tdi_sync_r <= 2'b00;
        end else begin
            tck_sync_r <= {tck_sync_r[1:0], jtag_TCK};
            tms_sync_r <= {tms_sync_r[0], jtag_TMS};
            tdi_sync_r <= {tdi_sync_r[0], jtag_TDI};
        end
    end

    assign tck_rise_s = tck_sync_r[1] & ~tck_sync_r[2];
    assign tck_fall_s = ~tck_sync_r[1] & tck_sync_r[2];
    assign tms_s      = tms_sync_r[1];
    assign tdi_s      = tdi_sync_r[1];

    jtag_tap_fsm u_tap (
        .clk        (clk),
        .rst        (rst),
        .tck_rise   (tck_rise_s),
        .tms        (tms_s),
        .capture_dr (capture_dr_s),
        .shift_dr   (shift_dr_s),
        .update_dr  (update_dr_s),
        .capture_ir (capture_ir_s),
        .shift_ir   (shift_ir_s),
        .update_ir  (update_ir_s),
        .tlr        (tlr_s)
    );

    assign dmi_status_s = outstanding_r ? DMI_STAT_BUSY : resp_r[1:0];

    // Instruction decode: DR selection and capture value
    always_comb begin
        dr_sel_s     = DR_BYPASS;
        dr_capture_s = '0;
        case (ir_r)
`ifdef JTAG_IDCODE_EN
            IR_BITS'(IR_IDCODE): begin
                dr_sel_s     = DR_WORD;
                dr_capture_s = DMI_W'(IDCODE_VAL);
            end
`endif
            IR_BITS'(IR_DTMCS): begin
                dr_sel_s     = DR_WORD;
                dr_capture_s = DMI_W'(dtmcs_word(dmistat_r, 6'(DMI_ABITS)));
            end
            IR_BITS'(IR_DMI): begin
                dr_sel_s     = DR_DMI;
                dr_capture_s = {dtm_req_data[DMI_W-1:34], resp_r[33:2], dmi_status_s};
            end
            default: begin
                dr_sel_s     = DR_BYPASS;
                dr_capture_s = '0;
            end
        endcase
    end

    // Right shift with TDI entering at the MSB of the selected register length
    always_comb begin
        dr_next_s = '0;
        case (dr_sel_s)
            DR_WORD: dr_next_s[31:0] = {tdi_s, dr_shift_r[31:1]};
            DR_DMI:  dr_next_s       = {tdi_s, dr_shift_r[DMI_W-1:1]};
            default: dr_next_s[0]    = tdi_s;
        endcase
    end

    // IR/DR shift paths, IR latch and TDO launch on the falling TCK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r       <= IR_RESET;
            ir_shift_r <= '0;
            dr_shift_r <= '0;
            jtag_TDO   <= 1'b0;
        end else begin
            if (tck_rise_s) begin
                if (capture_ir_s) begin
                    ir_shift_r <= IR_BITS'(IR_CAPTURE);
                end else if (shift_ir_s) begin
                    ir_shift_r <= {tdi_s, ir_shift_r[IR_BITS-1:1]};
                end
                if (capture_dr_s) begin
                    dr_shift_r <= dr_capture_s;
                end else if (shift_dr_s) begin
                    dr_shift_r <= dr_next_s;
                end
                if (update_ir_s) begin
                    ir_r <= ir_shift_r;
                end
            end
            if (tlr_s) begin
                ir_r <= IR_RESET;
            end
            if (tck_fall_s) begin
                if (shift_ir_s) begin
                    jtag_TDO <= ir_shift_r[0];
                end else if (shift_dr_s) begin
                    jtag_TDO <= dr_shift_r[0];
                end
            end
        end
    end

    assign resp_fire_s    = dm_resp_valid & dm_resp_ready;
    assign dmi_capture_s  = tck_rise_s & capture_dr_s & (dr_sel_s == DR_DMI);
    assign dmi_update_s   = tck_rise_s & update_dr_s & (ir_r == IR_BITS'(IR_DMI));
    assign dtmcs_update_s = tck_rise_s & update_dr_s & (ir_r == IR_BITS'(IR_DTMCS));
    assign hardreset_s    = dtmcs_update_s & dr_shift_r[DTMCS_HARDRESET_BIT];
    assign dmireset_s     = dtmcs_update_s &
                            (dr_shift_r[DTMCS_DMIRESET_BIT] | dr_shift_r[DTMCS_HARDRESET_BIT]);
    // A response landing this cycle frees the slot for a simultaneous update
    assign issue_s        = dmi_update_s &
                            ((dr_shift_r[1:0] == DMI_OP_READ) | (dr_shift_r[1:0] == DMI_OP_WRITE)) &
                            ~(outstanding_r & ~resp_fire_s) & (dmistat_r == 2'd0);

    // DMI request/response bookkeeping and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dtm_req_valid <= 1'b0;
            dtm_req_data  <= '0;
            dm_resp_ready <= 1'b1;
            resp_r        <= '0;
            outstanding_r <= 1'b0;
            dmistat_r     <= 2'd0;
        end else begin
            if (resp_fire_s) begin
                resp_r        <= dm_resp_data;
                outstanding_r <= 1'b0;
                dm_resp_ready <= 1'b0;
            end else if (dmi_capture_s) begin
                dm_resp_ready <= 1'b1;
            end
            if (dmi_capture_s && outstanding_r) begin
                dmistat_r <= DMI_STAT_BUSY;
            end else if (dmireset_s) begin
                dmistat_r <= 2'd0;
            end
            if (issue_s) begin
                dtm_req_data  <= dr_shift_r;
                dtm_req_valid <= 1'b1;
                outstanding_r <= 1'b1;
            end else if (dtm_req_valid && dtm_req_ready) begin
                dtm_req_valid <= 1'b0;
            end
            if (hardreset_s) begin
                dtm_req_valid <= 1'b0;
                outstanding_r <= 1'b0;
                resp_r        <= '0;
                dm_resp_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtag_dtm_sync.sv
// Self-checking bench for jtag_dtm_sync: bit-banged JTAG scans against a
// transaction-level model of the DTM registers and the DMI handshake.
module tb_jtag_dtm_sync;

    localparam int          HALF   = 6;
    localparam logic [31:0] IDCODE = 32'h1E200A6D;
`ifdef JTAG_IDCODE_EN
    localparam logic [4:0]  IR_RST = 5'h01;
`else
    localparam logic [4:0]  IR_RST = 5'h1F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
    logic        dtm_req_valid, dtm_req_ready;
    logic [39:0] dtm_req_data;
    logic        dm_resp_valid, dm_resp_ready;
    logic [33:0] dm_resp_data;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;

    // Model state
    logic [4:0]  m_ir;
    logic [1:0]  m_dmistat;
    logic        m_outstanding, m_held, m_valid;
    logic [33:0] m_resp;
    logic [39:0] m_req_data;

    jtag_dtm_sync dut (
        .clk           (clk),
        .rst           (rst),
        .jtag_TCK      (jtag_TCK),
        .jtag_TMS      (jtag_TMS),
        .jtag_TDI      (jtag_TDI),
        .jtag_TDO      (jtag_TDO),
        .dtm_req_valid (dtm_req_valid),
        .dtm_req_ready (dtm_req_ready),
        .dtm_req_data  (dtm_req_data),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_ready (dm_resp_ready),
        .dm_resp_data  (dm_resp_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dtm_req_valid) vcnt <= vcnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dr_len(input logic [4:0] ir);
        case (ir)
            5'h10:   return 32;
            5'h11:   return 40;
            default: begin
`ifdef JTAG_IDCODE_EN
                if (ir == 5'h01) return 32;
`endif
                return 1;
            end
        endcase
    endfunction

    function automatic logic [39:0] cap_val();
        case (m_ir)
            5'h10:   return {8'h0, 14'h0, 3'b000, 3'd5, m_dmistat, 6'd6, 4'd1};
            5'h11:   return {m_req_data[39:34], m_resp[33:2], m_outstanding ? 2'd3 : m_resp[1:0]};
            default: begin
`ifdef JTAG_IDCODE_EN
                if (m_ir == 5'h01) return {8'h0, IDCODE};
`endif
                return 40'h0;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_ir = IR_RST; m_dmistat = 2'd0; m_outstanding = 1'b0; m_held = 1'b0;
        m_valid = 1'b0; m_resp = 34'h0; m_req_data = 40'h0;
    endtask

    // One TCK period; returns TDO as seen just before the rising edge
    task automatic tck(input logic tms, input logic tdi, output logic tdo);
        tdo = jtag_TDO;
        jtag_TMS = tms; jtag_TDI = tdi; jtag_TCK = 1'b1;
        repeat (HALF) @(negedge clk);
        jtag_TCK = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic scan_ir(input logic [4:0] ir);
        logic       b;
        logic [4:0] irout;
        tck(1'b1, 1'b0, b); tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b); tck(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, ir[i], b);
            irout[i] = b;
        end
        tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b);
        check("ir_capture", 64'(irout), 64'h01);
        m_ir = ir;
    endtask

    task automatic scan_dr(input logic [39:0] din, output logic [39:0] dout);
        int          n;
        logic [39:0] cap;
        logic        b;
        n   = dr_len(m_ir);
        cap = cap_val();
        if (m_ir == 5'h11) begin
            if (m_outstanding) m_dmistat = 2'd3;
            m_held = 1'b0;
        end
        tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b); tck(1'b0, 1'b0, b);
        dout = 40'h0;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b);
        check("dr_out", 64'(dout), 64'(cap));
        if (m_ir == 5'h10) begin
            if (din[16] | din[17]) m_dmistat = 2'd0;
            if (din[17]) begin
                m_outstanding = 1'b0; m_held = 1'b0; m_resp = 34'h0; m_valid = 1'b0;
            end
        end else if (m_ir == 5'h11) begin
            if ((din[1:0] == 2'd1 || din[1:0] == 2'd2) && !m_outstanding && m_dmistat == 2'd0) begin
                m_req_data = din; m_valid = 1'b1; m_outstanding = 1'b1;
            end
        end
    endtask

    task automatic respond(input logic [33:0] d);
        check("resp_ready", 64'(dm_resp_ready), 64'(!m_held));
        dm_resp_valid = 1'b1; dm_resp_data = d;
        @(negedge clk);
        dm_resp_valid = 1'b0;
        if (!m_held) begin
            m_resp = d; m_held = 1'b1; m_outstanding = 1'b0;
        end
    endtask

    task automatic dmi_txn(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                           input int hold, input logic fast, output logic [39:0] dout);
        int c0;
        dtm_req_ready = fast;
        c0 = vcnt;
        scan_dr({a, d, op}, dout);
        if (fast) begin
            dtm_req_ready = 1'b0;
            check("fast_valid", 64'(dtm_req_valid), 64'h0);
            check("fast_pulse", 64'(vcnt - c0), m_valid ? 64'h1 : 64'h0);
            m_valid = 1'b0;
        end else begin
            check("req_valid", 64'(dtm_req_valid), 64'(m_valid));
            if (m_valid) begin
                check("req_data", 64'(dtm_req_data), 64'(m_req_data));
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    check("req_hold", 64'({dtm_req_valid, dtm_req_data}), 64'({1'b1, m_req_data}));
                end
                dtm_req_ready = 1'b1;
                @(negedge clk);
                dtm_req_ready = 1'b0;
                check("req_drop", 64'(dtm_req_valid), 64'h0);
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic reset_dut();
        logic b;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        tck(1'b0, 1'b0, b);
    endtask

    initial begin
        logic [39:0] dout;
        logic        b;
        logic [1:0]  op;
        jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0;
        dtm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_data = 34'h0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tdo", 64'(jtag_TDO), 64'h0);
        check("rst_valid", 64'(dtm_req_valid), 64'h0);
        check("rst_data", 64'(dtm_req_data), 64'h0);
        check("rst_resp_ready", 64'(dm_resp_ready), 64'h1);
        rst = 1'b0;
        @(negedge clk);
        tck(1'b0, 1'b0, b);

        // IR after reset, then explicit IDCODE selection
        scan_dr(40'(32'hA5A5_0F0F), dout);
        scan_ir(5'h01);
        scan_dr(40'h0, dout);
`ifdef JTAG_IDCODE_EN
        check("idcode", 64'(dout[31:0]), 64'h1E200A6D);
`endif

        // 8x TMS=1 from Shift-DR returns to Test-Logic-Reset without a request
        scan_ir(5'h11);
        tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b); tck(1'b0, 1'b0, b);
        m_held = 1'b0;
        repeat (8) tck(1'b1, 1'b0, b);
        m_ir = IR_RST;
        check("tlr_no_req", 64'(dtm_req_valid), 64'h0);
        tck(1'b0, 1'b0, b);
        scan_dr(40'(32'h1234_5678), dout);

        // Directed DMI write, read and nop readback
        scan_ir(5'h11);
        dmi_txn(6'h10, 32'h0, 2'b10, 5, 1'b0, dout);
        check("write_word", 64'(dtm_req_data), 64'h40_0000_0002);
        respond({32'hCAFE_0001, 2'b00});
        dmi_txn(6'h11, 32'h0, 2'b01, 0, 1'b0, dout);
        respond({32'h0003_0382, 2'b00});
        dmi_txn(6'h00, 32'h0, 2'b00, 0, 1'b0, dout);
        check("read_data", 64'(dout[33:2]), 64'h0003_0382);
        check("read_status", 64'(dout[1:0]), 64'h0);
        check("read_addr", 64'(dout[39:34]), 64'h11);

        // Busy: second scan while outstanding, then dmireset
        dmi_txn(6'h05, 32'h1111_2222, 2'b10, 1, 1'b0, dout);
        dmi_txn(6'h06, 32'h3333_4444, 2'b01, 0, 1'b0, dout);
        check("busy_status", 64'(dout[1:0]), 64'h3);
        scan_ir(5'h10);
        scan_dr(40'h1_0000, dout);
        check("dmistat_busy", 64'(dout[11:10]), 64'h3);
        respond({32'h5555_AAAA, 2'b00});
        scan_dr(40'h0, dout);
        check("dmistat_clear", 64'(dout[11:10]), 64'h0);

        // Randomised traffic
        for (int it = 0; it < 16; it++) begin
            if (m_ir != 5'h11) scan_ir(5'h11);
            op = 2'($urandom_range(0, 2));
            dmi_txn(6'($urandom), $urandom, op, $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0), dout);
            if (m_outstanding && $urandom_range(0, 2) != 0)
                respond({$urandom, 2'($urandom_range(0, 3))});
            if (m_dmistat != 2'd0 || $urandom_range(0, 4) == 0) begin
                scan_ir(5'h10);
                scan_dr({22'h0, ($urandom_range(0, 7) == 0),
                         (m_dmistat != 2'd0) | 1'($urandom), 16'($urandom)}, dout);
                check("dtmcs_after", 64'({dtm_req_valid, dm_resp_ready}), 64'({m_valid, !m_held}));
            end
        end

        // Reset in mid-handshake and mid-Shift-DR
        reset_dut();
        scan_ir(5'h11);
        dmi_txn(6'h2A, 32'hDEAD_BEEF, 2'b10, 0, 1'b0, dout);
        respond({32'h0, 2'b00});
        scan_ir(5'h11);
        dtm_req_ready = 1'b0;
        scan_dr({6'h15, 32'h0BAD_F00D, 2'b01}, dout);
        check("pend_valid", 64'(dtm_req_valid), 64'h1);
        scan_ir(5'h01);
        tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b); tck(1'b0, 1'b0, b);
        check("pre_rst_tdo", 64'(jtag_TDO), 64'(cap_val() & 40'h1));
        rst = 1'b1;
        #1;
        check("async_valid", 64'(dtm_req_valid), 64'h0);
        check("async_tdo", 64'(jtag_TDO), 64'h0);
        check("async_data", 64'(dtm_req_data), 64'h0);
        check("async_resp_ready", 64'(dm_resp_ready), 64'h1);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        tck(1'b0, 1'b0, b);
        scan_dr(40'(32'h0F0F_F0F0), dout);
        check("post_rst_valid", 64'(dtm_req_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
